maxpool_backprop: RTL and testbench

- Backward-pass companion to the 2x2/stride-2 max-pool stage in the TCB_CNN datapath.
- Captures one forward feature map (10x10 flattened) and records the argmax position of each 2x2 window.
- Accepts the 25 upstream pooled gradients as a serial valid/ready stream.
- Scatters each gradient to its window's argmax position, zeroes all other positions, and emits the 100-element gradient map for the preceding conv layer's weight update.

---
 rtl/maxpool_backprop_pkg.sv | 35 +++
 rtl/maxpool_backprop_argmax4.sv | 30 +++
 rtl/maxpool_backprop.sv | 133 +++++++++++++
 tb/tb_maxpool_backprop.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/maxpool_backprop_pkg.sv
// Shared definitions for the 2x2/stride-2 max-pool backward pass:
// state encoding, map-size derivation and window-to-position mapping.
package maxpool_backprop_pkg;

    localparam int IDX_W = 2;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_CAPTURE   = 3'd1;
    localparam logic [2:0] ST_ARGMAX    = 3'd2;
    localparam logic [2:0] ST_WAIT_GRAD = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_CAPTURE   = ST_CAPTURE,
        S_ARGMAX    = ST_ARGMAX,
        S_WAIT_GRAD = ST_WAIT_GRAD,
        S_DONE      = ST_DONE
    } state_e;

    function automatic int input_node(input int w, input int h);
        return w * h;
    endfunction

    function automatic int output_node(input int w, input int h);
        return (w / 2) * (h / 2);
    endfunction

    // Flat row-major position of element {dr,dc} inside window (r,c).
    function automatic int win_pos(input int r, input int c,
                                   input logic [IDX_W-1:0] idx, input int in_w);
        return (2 * r + int'(idx[1])) * in_w + 2 * c + int'(idx[0]);
    endfunction

endpackage

// File: rtl/maxpool_backprop_argmax4.sv
// Combinational argmax of one 2x2 window; ties resolve right-over-left
// within a row and bottom-over-top between rows.
module pool_argmax4
    import maxpool_backprop_pkg::*;
#(
    parameter int DATA_WIDTH = 19
) (
    input  logic signed [DATA_WIDTH-1:0] tl_i,
    input  logic signed [DATA_WIDTH-1:0] tr_i,
    input  logic signed [DATA_WIDTH-1:0] bl_i,
    input  logic signed [DATA_WIDTH-1:0] br_i,
    output logic        [IDX_W-1:0]      idx_o
);

    logic                         top_dc;
    logic                         bot_dc;
    logic                         dr;
    logic signed [DATA_WIDTH-1:0] top_max;
    logic signed [DATA_WIDTH-1:0] bot_max;

    always_comb begin
        top_dc  = (tr_i >= tl_i);
        bot_dc  = (br_i >= bl_i);
        top_max = top_dc ? tr_i : tl_i;
        bot_max = bot_dc ? br_i : bl_i;
        dr      = (bot_max >= top_max);
        idx_o   = {dr, (dr ? bot_dc : top_dc)};
    end

endmodule

// File: rtl/maxpool_backprop.sv
// Max-pool backward pass: latches per-window argmax from a forward map, then
// scatters a serial stream of pooled gradients onto those positions.
module maxpool_backprop
    import maxpool_backprop_pkg::*;
#(
    parameter int DATA_WIDTH  = 19,
    parameter int IN_W        = 10,
    parameter int IN_H        = 10,
    parameter int INPUT_NODE  = input_node(IN_W, IN_H),
    parameter int OUTPUT_NODE = output_node(IN_W, IN_H)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_WIDTH*INPUT_NODE-1:0] fwd_in,
    input  logic                             fwd_valid,
    output logic                             idx_ready,
    input  logic [DATA_WIDTH-1:0]            grad_in,
    input  logic                             grad_valid,
    output logic                             grad_ready,
    output logic [DATA_WIDTH*INPUT_NODE-1:0] grad_out,
    output logic                             grad_out_valid,
    output logic                             busy
);

    localparam int HALF_W = IN_W / 2;
    localparam int HALF_H = IN_H / 2;
    localparam int POS_W  = $clog2(INPUT_NODE);
    localparam int WIN_W  = (OUTPUT_NODE > 1) ? $clog2(OUTPUT_NODE) : 1;
    localparam int CW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;
    localparam int RW     = (HALF_H > 1) ? $clog2(HALF_H) : 1;

    state_e                       state_q, state_d;
    logic signed [DATA_WIDTH-1:0] in_buf_q   [INPUT_NODE];
    logic signed [DATA_WIDTH-1:0] grad_buf_q [INPUT_NODE];
    logic        [IDX_W-1:0]      idx_q      [OUTPUT_NODE];
    logic        [IDX_W-1:0]      idx_w      [OUTPUT_NODE];
    logic        [CW-1:0]         c_q;
    logic        [RW-1:0]         r_q;
    logic                         beat_acc;
    logic                         last_beat;
    logic        [WIN_W-1:0]      win;
    logic        [POS_W-1:0]      wr_pos;

    assign idx_ready      = (state_q == S_WAIT_GRAD);
    assign grad_ready     = (state_q == S_WAIT_GRAD);
    assign grad_out_valid = (state_q == S_DONE);
    assign busy           = (state_q != S_IDLE);

    assign beat_acc  = grad_ready && grad_valid;
    assign last_beat = beat_acc && (r_q == RW'(HALF_H - 1)) && (c_q == CW'(HALF_W - 1));
    assign win       = WIN_W'(int'(r_q) * HALF_W + int'(c_q));
    assign wr_pos    = POS_W'(win_pos(int'(r_q), int'(c_q), idx_q[win], IN_W));

    for (genvar r = 0; r < HALF_H; r++) begin : g_row
        for (genvar c = 0; c < HALF_W; c++) begin : g_col
            localparam int W    = r * HALF_W + c;
            localparam int P_TL = win_pos(r, c, 2'b00, IN_W);
            localparam int P_TR = win_pos(r, c, 2'b01, IN_W);
            localparam int P_BL = win_pos(r, c, 2'b10, IN_W);
            localparam int P_BR = win_pos(r, c, 2'b11, IN_W);
            pool_argmax4 #(.DATA_WIDTH(DATA_WIDTH)) u_argmax (
                .tl_i  (in_buf_q[P_TL]),
                .tr_i  (in_buf_q[P_TR]),
                .bl_i  (in_buf_q[P_BL]),
                .br_i  (in_buf_q[P_BR]),
                .idx_o (idx_w[W])
            );
        end
    end

    for (genvar j = 0; j < INPUT_NODE; j++) begin : g_pack
        assign grad_out[j*DATA_WIDTH +: DATA_WIDTH] = grad_buf_q[j];
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (fwd_valid) state_d = S_CAPTURE;
            S_CAPTURE:   state_d = S_ARGMAX;
            S_ARGMAX:    state_d = S_WAIT_GRAD;
            S_WAIT_GRAD: if (last_beat) state_d = S_DONE;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < INPUT_NODE; j++) begin
                in_buf_q[j]   <= '0;
                grad_buf_q[j] <= '0;
            end
            for (int w = 0; w < OUTPUT_NODE; w++) idx_q[w] <= '0;
            r_q <= '0;
            c_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (fwd_valid)
                        for (int j = 0; j < INPUT_NODE; j++)
                            in_buf_q[j] <= fwd_in[j*DATA_WIDTH +: DATA_WIDTH];
                end
                S_CAPTURE: begin
                    for (int j = 0; j < INPUT_NODE; j++) grad_buf_q[j] <= '0;
                    r_q <= '0;
                    c_q <= '0;
                end
                S_ARGMAX: begin
                    for (int w = 0; w < OUTPUT_NODE; w++) idx_q[w] <= idx_w[w];
                end
                S_WAIT_GRAD: begin
                    // Row/col walk of the window grid avoids dividing the beat number.
                    if (beat_acc) begin
                        grad_buf_q[wr_pos] <= grad_in;
                        if (c_q == CW'(HALF_W - 1)) begin
                            c_q <= '0;
                            r_q <= r_q + RW'(1);
                        end else begin
                            c_q <= c_q + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_maxpool_backprop.sv
// Scoreboard bench for maxpool_backprop: expected gradient maps are queued
// when each frame is launched and compared on every grad_out_valid pulse.
module tb_maxpool_backprop;

    localparam int DW = 19;
    localparam int NI = 100;
    localparam int NO = 25;
    localparam int NB = DW * NI;

    logic          clk;
    logic          rst;
    logic [NB-1:0] fwd_in;
    logic          fwd_valid;
    logic          idx_ready;
    logic [DW-1:0] grad_in;
    logic          grad_valid;
    logic          grad_ready;
    logic [NB-1:0] grad_out;
    logic          grad_out_valid;
    logic          busy;

    int tests_run = 0;
    int tests_failed = 0;
    int pulses = 0;

    logic [DW-1:0] gvals [NO];
    logic [NB-1:0] exp_q [$];
    logic [NB-1:0] mon_exp;

    maxpool_backprop dut (
        .clk            (clk),
        .rst            (rst),
        .fwd_in         (fwd_in),
        .fwd_valid      (fwd_valid),
        .idx_ready      (idx_ready),
        .grad_in        (grad_in),
        .grad_valid     (grad_valid),
        .grad_ready     (grad_ready),
        .grad_out       (grad_out),
        .grad_out_valid (grad_out_valid),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] gout(input int p);
        return grad_out[p*DW +: DW];
    endfunction

    // Reference: the window max, later scan order (tl,tr,bl,br) winning ties.
    function automatic logic [NB-1:0] model(input logic [NB-1:0] f);
        logic [NB-1:0]        e;
        logic signed [DW-1:0] v, bv;
        int                   best, p;
        e = '0;
        for (int w = 0; w < NO; w++) begin
            best = 0;
            bv   = '0;
            for (int d = 0; d < 4; d++) begin
                p = (2 * (w / 5) + d / 2) * 10 + 2 * (w % 5) + d % 2;
                v = f[p*DW +: DW];
                if (d == 0 || v >= bv) begin
                    bv   = v;
                    best = p;
                end
            end
            e[best*DW +: DW] = gvals[w];
        end
        return e;
    endfunction

    function automatic logic [NB-1:0] map_topleft();
        logic [NB-1:0] f;
        int            p;
        f = '0;
        for (int w = 0; w < NO; w++) begin
            p = (2 * (w / 5)) * 10 + 2 * (w % 5);
            f[p*DW +: DW]        = DW'(5);
            f[(p+1)*DW +: DW]    = DW'(1);
            f[(p+10)*DW +: DW]   = DW'(2);
            f[(p+11)*DW +: DW]   = DW'(3);
        end
        return f;
    endfunction

    function automatic logic [NB-1:0] map_random();
        logic [NB-1:0] f;
        int            v;
        for (int j = 0; j < NI; j++) begin
            v = int'($urandom_range(0, 6)) - 3;
            f[j*DW +: DW] = DW'(v);
        end
        return f;
    endfunction

    always @(negedge clk) begin
        if (grad_out_valid) begin
            pulses++;
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 64'd1, 64'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                for (int j = 0; j < NI; j++)
                    check($sformatf("gout[%0d]", j), grad_out[j*DW +: DW], mon_exp[j*DW +: DW]);
            end
        end
    end

    task automatic run_frame(input logic [NB-1:0] fmap, input logic [NB-1:0] alt,
                             input bit stall, input bit inject, input int abort_at);
        int k, cyc, lat;
        bit gv, rdy;
        int pat [4];
        pat = '{1, 0, 0, 1};
        exp_q.push_back(model(fmap));
        @(negedge clk);
        fwd_in    = fmap;
        fwd_valid = 1'b1;
        @(negedge clk);
        fwd_valid = 1'b0;
        lat = 1;
        while (!grad_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("ready_latency", 64'(lat), 64'd3);
        k   = 0;
        cyc = 0;
        while (k < NO && cyc < 400) begin
            gv         = stall ? (pat[cyc % 4] != 0) : 1'b1;
            grad_valid = gv;
            grad_in    = gvals[k];
            if (inject && cyc == 2) begin
                fwd_valid = 1'b1;
                fwd_in    = alt;
            end else begin
                fwd_valid = 1'b0;
            end
            rdy = grad_ready;
            @(negedge clk);
            cyc++;
            if (gv && rdy) k++;
            if (inject && cyc == 3) begin
                check("inject_busy", 64'(busy), 64'd1);
                check("inject_idx_ready", 64'(idx_ready), 64'd1);
            end
            if (abort_at >= 0 && k == abort_at) break;
        end
        grad_valid = 1'b0;
        fwd_valid  = 1'b0;
        if (abort_at >= 0) begin
            exp_q.delete();
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("abort_gout_zero", 64'(grad_out != '0), 64'd0);
            check("abort_busy", 64'(busy), 64'd0);
            check("abort_grad_ready", 64'(grad_ready), 64'd0);
            check("abort_idx_ready", 64'(idx_ready), 64'd0);
            return;
        end
        check("beats_accepted", 64'(k), 64'd25);
        check("done_grad_ready", 64'(grad_ready), 64'd0);
        check("done_valid", 64'(grad_out_valid), 64'd1);
        check("done_idx_ready", 64'(idx_ready), 64'd0);
        @(negedge clk);
        check("valid_single_pulse", 64'(grad_out_valid), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NB-1:0] ma, mb;
        rst        = 1'b1;
        fwd_valid  = 1'b0;
        grad_valid = 1'b0;
        fwd_in     = '0;
        grad_in    = '0;
        repeat (3) @(negedge clk);
        check("rst_idx_ready", 64'(idx_ready), 64'd0);
        check("rst_grad_ready", 64'(grad_ready), 64'd0);
        check("rst_gout_zero", 64'(grad_out != '0), 64'd0);
        check("rst_gout_valid", 64'(grad_out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;

        grad_valid = 1'b1;
        @(negedge clk);
        check("idle_ignore_grad_ready", 64'(grad_ready), 64'd0);
        check("idle_ignore_busy", 64'(busy), 64'd0);
        grad_valid = 1'b0;

        // Basic scatter
        for (int k = 0; k < NO; k++) gvals[k] = DW'(k + 1);
        ma = map_topleft();
        run_frame(ma, '0, 1'b0, 1'b0, -1);
        check("basic_pos0", 64'(gout(0)), 64'd1);
        check("basic_pos2", 64'(gout(2)), 64'd2);
        check("basic_pos20", 64'(gout(20)), 64'd6);
        check("basic_pos88", 64'(gout(88)), 64'd25);

        // Signed compare and tie rule
        mb = map_random();
        mb[0*DW +: DW]  = DW'(-3);
        mb[1*DW +: DW]  = DW'(-3);
        mb[10*DW +: DW] = DW'(-7);
        mb[11*DW +: DW] = DW'(-3);
        mb[2*DW +: DW]  = DW'(-1);
        mb[3*DW +: DW]  = DW'(-5);
        mb[12*DW +: DW] = DW'(-2);
        mb[13*DW +: DW] = DW'(-4);
        for (int k = 0; k < NO; k++) gvals[k] = DW'($urandom);
        gvals[0] = DW'(9);
        gvals[1] = DW'(-11);
        run_frame(mb, '0, 1'b0, 1'b0, -1);
        check("tie_pos11", 64'(gout(11)), 64'd9);
        check("tie_pos0", 64'(gout(0)), 64'd0);
        check("tie_pos1", 64'(gout(1)), 64'd0);
        check("tie_pos10", 64'(gout(10)), 64'd0);
        check("signed_pos2", 64'(gout(2)), 64'(gvals[1]));

        // Backpressure with the basic frame
        for (int k = 0; k < NO; k++) gvals[k] = DW'(k + 1);
        run_frame(ma, '0, 1'b1, 1'b0, -1);
        check("stall_pos88", 64'(gout(88)), 64'd25);

        // fwd_valid during WAIT_GRAD must be ignored
        for (int k = 0; k < NO; k++) gvals[k] = DW'($urandom);
        run_frame(map_random(), ma, 1'b0, 1'b1, -1);

        // Abort after 12 beats, then a full fresh frame
        run_frame(map_random(), '0, 1'b0, 1'b0, 12);
        for (int k = 0; k < NO; k++) gvals[k] = DW'($urandom);
        run_frame(map_random(), '0, 1'b1, 1'b0, -1);

        repeat (3) @(negedge clk);
        check("pulse_count", 64'(pulses), 64'd5);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
